bioram_port_ctrl: RTL
=====================

BIORAM_PORT_CTRL -- requirements
Module: bioram_port_ctrl

Interface
REQ-001 SHALL have parameter EMA, default 3'b010, read margin driven on ram_ema.
REQ-002 SHALL have parameter EMAW, default 2'b00, write margin driven on ram_emaw.
REQ-003 SHALL have parameter EMAS, default 1'b0, driven on ram_emas.
REQ-004 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port req_valid, input, 1, request present.
REQ-007 SHALL have port req_ready, output, 1, request accepted when req_valid&&req_ready.
REQ-008 SHALL have port req_we, input, 1, 1=write, 0=read.
REQ-009 SHALL have port req_addr, input, 12, byte address; word address = req_addr[11:2]; req_addr[1:0] ignored.
REQ-010 SHALL have port req_wdata, input, 32, write data.
REQ-011 SHALL have port req_strb, input, 4, byte strobes; bit k covers bits 8k+7:8k.
REQ-012 SHALL have port resp_valid, output, 1, read data available.
REQ-013 SHALL have port resp_ready, input, 1, consumer takes resp_rdata when resp_valid&&resp_ready.
REQ-014 SHALL have port resp_rdata, output, 32, read data.
REQ-015 SHALL have SRAM-side outputs ram_cen (1, active-low), ram_gwen (1, active-low), ram_wen (32, active-low per bit), ram_a (10), ram_d (32), ram_ema (3), ram_emaw (2), ram_emas (1), ram_ret1n (1), ram_wabl (1), ram_wablm (2), ram_rawl (1), ram_rawlm (2), and input ram_q (32) connecting to the 1Kx32 SRAM macro.

Function
REQ-016 SHALL tie ram_ret1n=1, ram_wabl=0, ram_wablm=0, ram_rawl=0, ram_rawlm=0, margins from parameters.
REQ-017 SHALL drive ram_a=req_addr[11:2] and ram_d=req_wdata combinationally.
REQ-018 SHALL assert ram_cen=0 in a cycle only when a request is accepted and (req_we=0 or req_strb!=0); otherwise ram_cen=1.
REQ-019 Accepted read: ram_gwen=1, ram_wen=all ones.
REQ-020 Accepted write: ram_gwen=0; ram_wen[8k+7:8k]=0 when req_strb[k]=1, else all ones.
REQ-021 Write with req_strb=0 SHALL be accepted and consume no SRAM cycle (ram_cen=1); writes produce no response.
REQ-022 SHALL hold a 1-bit rd_inflight flag, set on the edge ending a read-accept cycle, cleared otherwise.
REQ-023 SHALL capture ram_q into a 2-entry response FIFO on the edge ending each cycle where rd_inflight=1.
REQ-024 Read latency: read accepted in cycle N -> resp_valid=1 with its data no earlier than cycle N+2 (exactly N+2 when FIFO empty).
REQ-025 Responses SHALL return in acceptance order; resp_rdata/resp_valid stable while resp_valid&&!resp_ready.
REQ-026 With count=FIFO occupancy and pop=resp_valid&&resp_ready: req_ready=((count+rd_inflight-pop)<2); req_ready may depend combinationally on resp_ready; same rule for reads and writes.
REQ-027 Push and pop in the same edge SHALL leave count unchanged; FIFO pointers wrap modulo 2; FIFO never overflows (guaranteed by REQ-026).
REQ-028 Read following a write to same word in next cycle SHALL return the newly written bytes.
REQ-029 resp_valid=(count!=0); resp_rdata=FIFO head (don't-care when empty).

Reset
REQ-030 While reset=1: ram_cen=1, ram_gwen=1, ram_wen=all ones, req_ready=0, resp_valid=0, count=0, rd_inflight=0.
REQ-031 Reset asserted mid-operation SHALL discard in-flight read and all queued responses; no response after deassertion.
REQ-032 First request SHALL be acceptable in the first cycle after reset deasserts.

Verification
REQ-033 Write addr 0x004 data 0xDEADBEEF strb 4'hF, then read 0x004 -> ram_wen=0 on write cycle; resp_rdata=0xDEADBEEF two cycles after read accept.
REQ-034 Write 0x004 data 0x11223344 strb 4'b0010 over prior 0xDEADBEEF, read -> ram_wen=32'hFFFF00FF; resp_rdata=0xDEAD33EF.
REQ-035 Write strb 4'h0 -> accepted, ram_cen=1, memory unchanged.
REQ-036 Back-to-back reads 0x000,0x004,0x008 with resp_ready=0 -> two accepted, req_ready=0 thereafter; raising resp_ready yields responses in order, third accepted same cycle as first pop.
REQ-037 Continuous reads with resp_ready=1 -> one accept and one response per cycle, no bubbles.
REQ-038 Assert reset one cycle after read accept -> resp_valid stays 0 after reset; outputs at REQ-030 values during reset.

Source files
------------

// File: rtl/bioram_port_ctrl.sv
// bioram_port_ctrl
//   Request/response front end for a 1Kx32 single-port SRAM macro.
//   Requests are forwarded to the macro in the cycle they are accepted.
//   Read data returns from the macro one cycle later and is captured into
//   a 2-entry response FIFO, so a read response appears two cycles after
//   acceptance at the earliest. Writes produce no response.
//
// Ports
//   clk, reset          : sole clock (rising edge); asynchronous active-high reset
//   req_*               : request channel (valid/ready), byte address, data, strobes
//   resp_*              : response channel (valid/ready), read data
//   ram_*               : SRAM macro pins (active-low enables, margins, tie-offs)
module bioram_port_ctrl #(
  parameter logic [2:0] EMA  = 3'b010,
  parameter logic [1:0] EMAW = 2'b00,
  parameter logic       EMAS = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_strb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        ram_cen,
  output logic        ram_gwen,
  output logic [31:0] ram_wen,
  output logic [9:0]  ram_a,
  output logic [31:0] ram_d,
  output logic [2:0]  ram_ema,
  output logic [1:0]  ram_emaw,
  output logic        ram_emas,
  output logic        ram_ret1n,
  output logic        ram_wabl,
  output logic [1:0]  ram_wablm,
  output logic        ram_rawl,
  output logic [1:0]  ram_rawlm,
  input  logic [31:0] ram_q
);

  // Expand byte strobes into the macro's active-low per-bit write enables.
  function automatic logic [31:0] strb_to_wen(input logic [3:0] strb);
    logic [31:0] wen;
    wen = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) begin
        wen[8*k +: 8] = 8'h00;
      end else begin
        wen[8*k +: 8] = 8'hFF;
      end
    end
    return wen;
  endfunction

  logic        rd_inflight_q, rd_inflight_d;
  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [31:0] fifo_q [2];
  logic [31:0] fifo_d [2];

  logic        pop_s;
  logic        push_s;
  logic        accept_s;
  logic        rd_acc_s;
  logic        wr_acc_s;
  logic [2:0]  occ_s;
  logic [1:0]  unused_addr_s;

  assign unused_addr_s = req_addr[1:0];

  // Constant macro pins: margins from parameters, retention off, assists off.
  assign ram_ema   = EMA;
  assign ram_emaw  = EMAW;
  assign ram_emas  = EMAS;
  assign ram_ret1n = 1'b1;
  assign ram_wabl  = 1'b0;
  assign ram_wablm = 2'b00;
  assign ram_rawl  = 1'b0;
  assign ram_rawlm = 2'b00;

  // Handshake, macro control and FIFO next-state.
  always_comb begin
    ram_a      = req_addr[11:2];
    ram_d      = req_wdata;
    resp_valid = (count_q != 2'd0);
    resp_rdata = fifo_q[rd_ptr_q];
    pop_s      = resp_valid && resp_ready;
    push_s     = rd_inflight_q;

    // Occupancy seen by a new request: queued + in flight - leaving now.
    // A slot freed by a same-cycle pop may be reused immediately.
    occ_s = {1'b0, count_q} + {2'b00, rd_inflight_q} - {2'b00, pop_s};

    if (reset) begin
      req_ready = 1'b0;
    end else begin
      req_ready = (occ_s < 3'd2);
    end

    accept_s = req_valid && req_ready;
    rd_acc_s = accept_s && !req_we;
    // A write with no strobes is accepted but never touches the macro.
    wr_acc_s = accept_s && req_we && (req_strb != 4'h0);

    ram_cen = !(rd_acc_s || wr_acc_s);
    if (accept_s && req_we) begin
      ram_gwen = 1'b0;
      ram_wen  = strb_to_wen(req_strb);
    end else begin
      ram_gwen = 1'b1;
      ram_wen  = 32'hFFFF_FFFF;
    end

    rd_inflight_d = rd_acc_s;
    count_d       = count_q + {1'b0, push_s} - {1'b0, pop_s};
    wr_ptr_d      = wr_ptr_q ^ push_s;
    rd_ptr_d      = rd_ptr_q ^ pop_s;
    fifo_d        = fifo_q;
    if (push_s) begin
      fifo_d[wr_ptr_q] = ram_q;
    end else begin
      fifo_d[wr_ptr_q] = fifo_q[wr_ptr_q];
    end
  end

  // State registers; reset drops any in-flight read and queued responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_inflight_q <= 1'b0;
      count_q       <= 2'd0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      fifo_q[0]     <= 32'd0;
      fifo_q[1]     <= 32'd0;
    end else begin
      rd_inflight_q <= rd_inflight_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_q        <= fifo_d;
    end
  end

endmodule
